time_keeper: RTL and testbench

Sequential time source feeding the alarm display stage. Divides the system clock into time units and keeps a wrapping 4-bit current-time count. Holds a 4-bit alarm time loaded from a keypad-style key handshake. Generates a timed show-alarm strobe. Its current_time, alarm_time and show_a outputs drive the display stage's inputs of the same names.

---
 rtl/time_keeper.sv | 152 +++++++++++++++
 tb/tb_time_keeper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// time_keeper: time source for the alarm display stage.
//   Divides clock into time units (TICKS_PER_UNIT cycles each) and advances a
//   wrapping current_time (0..MAX_COUNT). Loads current_time or alarm_time from
//   a key handshake after a one-cycle load command, with range check and timeout.
//   Generates a retriggerable show_a strobe of SHOW_CYCLES cycles.
// Ports:
//   clock, reset (sync, active-high)
//   load_time, load_alarm  one-cycle commands selecting the target of the next key
//   key_valid, key_value   key handshake
//   show_alarm_req         one-cycle request to display alarm time
//   current_time, alarm_time, show_a, tick, busy, key_error  registered outputs
module time_keeper #(
  parameter int TICKS_PER_UNIT = 4,
  parameter int MAX_COUNT      = 9,
  parameter int SHOW_CYCLES    = 3,
  parameter int KEY_TIMEOUT    = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load_time,
  input  logic       load_alarm,
  input  logic       key_valid,
  input  logic [3:0] key_value,
  input  logic       show_alarm_req,
  output logic [3:0] current_time,
  output logic [3:0] alarm_time,
  output logic       show_a,
  output logic       tick,
  output logic       busy,
  output logic       key_error
);

  localparam int PW = $clog2(TICKS_PER_UNIT);
  localparam int TW = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
  localparam int SW = $clog2(SHOW_CYCLES + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_UNIT - 1);
  localparam logic [3:0]    MAX_VAL   = 4'(MAX_COUNT);
  localparam logic [TW-1:0] TO_LAST   = TW'(KEY_TIMEOUT - 1);
  localparam logic [SW-1:0] SHOW_LOAD = SW'(SHOW_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT_TIME, WAIT_ALARM} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] to_q, to_d;
  logic [SW-1:0] show_cnt_q, show_cnt_d;
  logic [3:0]    current_time_q, current_time_d;
  logic [3:0]    alarm_time_q, alarm_time_d;
  logic          show_a_q, show_a_d;
  logic          tick_q, tick_d;
  logic          busy_q, busy_d;
  logic          key_error_q, key_error_d;

  always_comb begin
    state_d        = state_q;
    pre_d          = pre_q;
    to_d           = to_q;
    show_cnt_d     = show_cnt_q;
    current_time_d = current_time_q;
    alarm_time_d   = alarm_time_q;
    tick_d         = 1'b0;
    key_error_d    = 1'b0;

    // Time base is frozen while waiting for a new current_time.
    if (state_q != WAIT_TIME) begin
      if (pre_q == PRE_LAST) begin
        pre_d          = '0;
        tick_d         = 1'b1;
        current_time_d = (current_time_q == MAX_VAL) ? '0 : current_time_q + 4'd1;
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        to_d = '0;
        if (load_time) begin
          state_d = WAIT_TIME;
        end else if (load_alarm) begin
          state_d = WAIT_ALARM;
        end
      end
      WAIT_TIME, WAIT_ALARM: begin
        // A key on the last timeout cycle takes priority over the timeout.
        if (key_valid) begin
          if (key_value <= MAX_VAL) begin
            if (state_q == WAIT_TIME) begin
              current_time_d = key_value;
              pre_d          = '0;
            end else begin
              alarm_time_d = key_value;
            end
          end else begin
            key_error_d = 1'b1;
          end
          state_d = IDLE;
        end else if (to_q == TO_LAST) begin
          key_error_d = 1'b1;
          state_d     = IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (show_alarm_req) begin
      show_cnt_d = SHOW_LOAD;
    end else if (show_cnt_q != '0) begin
      show_cnt_d = show_cnt_q - SW'(1);
    end

    show_a_d = (show_cnt_d != '0);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      pre_q          <= '0;
      to_q           <= '0;
      show_cnt_q     <= '0;
      current_time_q <= '0;
      alarm_time_q   <= '0;
      show_a_q       <= 1'b0;
      tick_q         <= 1'b0;
      busy_q         <= 1'b0;
      key_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      to_q           <= to_d;
      show_cnt_q     <= show_cnt_d;
      current_time_q <= current_time_d;
      alarm_time_q   <= alarm_time_d;
      show_a_q       <= show_a_d;
      tick_q         <= tick_d;
      busy_q         <= busy_d;
      key_error_q    <= key_error_d;
    end
  end

  assign current_time = current_time_q;
  assign alarm_time   = alarm_time_q;
  assign show_a       = show_a_q;
  assign tick         = tick_q;
  assign busy         = busy_q;
  assign key_error    = key_error_q;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper: a driver applies directed and random
// stimulus, an event-time reference model pushes the expected outputs for each
// clock edge, and a monitor pops and compares after every edge.
module tb_time_keeper;

  localparam int TPU  = 4;
  localparam int MAXC = 9;
  localparam int SHOW = 3;
  localparam int KTO  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_time = 1'b0;
  logic       load_alarm = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       show_alarm_req = 1'b0;
  logic [3:0] current_time;
  logic [3:0] alarm_time;
  logic       show_a;
  logic       tick;
  logic       busy;
  logic       key_error;

  time_keeper #(
    .TICKS_PER_UNIT(TPU),
    .MAX_COUNT     (MAXC),
    .SHOW_CYCLES   (SHOW),
    .KEY_TIMEOUT   (KTO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_time     (load_time),
    .load_alarm    (load_alarm),
    .key_valid     (key_valid),
    .key_value     (key_value),
    .show_alarm_req(show_alarm_req),
    .current_time  (current_time),
    .alarm_time    (alarm_time),
    .show_a        (show_a),
    .tick          (tick),
    .busy          (busy),
    .key_error     (key_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint     edge_no;
    logic [3:0] ct;
    logic [3:0] at;
    logic       show;
    logic       tick;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Reference model in terms of absolute edge numbers / deadlines.
  longint e = 0;
  longint next_tick = 0;
  longint deadline = 0;
  longint show_until = -1;
  int     m_time = 0;
  int     m_alarm = 0;
  int     mode = 0;  // 0 idle, 1 waiting for time key, 2 waiting for alarm key

  task automatic model(input logic r, input logic lt, input logic la,
                       input logic kv, input logic [3:0] kval, input logic sr);
    exp_t x;
    x.edge_no = e;
    x.tick = 1'b0;
    x.err  = 1'b0;
    if (r) begin
      m_time = 0; m_alarm = 0; mode = 0;
      next_tick = e + TPU;
      show_until = -1;
    end else begin
      if (mode == 1) begin
        next_tick = next_tick + 1;
      end else if (e == next_tick) begin
        x.tick = 1'b1;
        m_time = (m_time == MAXC) ? 0 : m_time + 1;
        next_tick = next_tick + TPU;
      end
      if (mode == 0) begin
        if (lt) begin mode = 1; deadline = e + KTO; end
        else if (la) begin mode = 2; deadline = e + KTO; end
      end else begin
        if (kv) begin
          if (int'(kval) <= MAXC) begin
            if (mode == 1) begin m_time = int'(kval); next_tick = e + TPU; end
            else m_alarm = int'(kval);
          end else begin
            x.err = 1'b1;
          end
          mode = 0;
        end else if (e == deadline) begin
          x.err = 1'b1;
          mode = 0;
        end
      end
      if (sr) show_until = e + SHOW - 1;
    end
    x.show = (e <= show_until);
    x.busy = (mode != 0);
    x.ct   = 4'(m_time);
    x.at   = 4'(m_alarm);
    sb.push_back(x);
    e = e + 1;
  endtask

  task automatic step(input logic r, input logic lt, input logic la,
                      input logic kv, input logic [3:0] kval, input logic sr);
    reset = r; load_time = lt; load_alarm = la;
    key_valid = kv; key_value = kval; show_alarm_req = sr;
    @(posedge clock);
    model(r, lt, la, kv, kval, sr);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic chk(input string nm, input longint en, input logic [3:0] act, input logic [3:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", nm, en, act, want);
    end
  endtask

  exp_t m_e;
  always @(posedge clock) begin
    #2;
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      chk("current_time", m_e.edge_no, current_time, m_e.ct);
      chk("alarm_time",   m_e.edge_no, alarm_time,   m_e.at);
      chk("show_a",       m_e.edge_no, {3'b0, show_a},    {3'b0, m_e.show});
      chk("tick",         m_e.edge_no, {3'b0, tick},      {3'b0, m_e.tick});
      chk("busy",         m_e.edge_no, {3'b0, busy},      {3'b0, m_e.busy});
      chk("key_error",    m_e.edge_no, {3'b0, key_error}, {3'b0, m_e.err});
    end
  end

  initial begin
    @(negedge clock);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    idle(45);                                      // free run through wrap
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);      // alarm load, key 7 two cycles later
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);      // time load, wait, key 5
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);      // out-of-range alarm key
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);      // alarm timeout
    idle(10);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);      // time timeout
    idle(10);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);      // show retrigger
    idle(1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    idle(8);
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);      // both loads: time wins
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);      // key on final timeout cycle
    idle(KTO - 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);      // time key on final cycle, at MAX
    idle(KTO - 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'(MAXC), 1'b0);
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);      // reset in WAIT_ALARM with key
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 5) == 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 9) == 0));
    end
    repeat (3) @(posedge clock);
    #3;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
